mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one memory/IO bus between two masters: M0 = multicycle CPU (addr/data/mem_w/CPU_MIO side),
//  M1 = secondary master (DMA or display fetch). Round-robin arbitration, one transaction at a time.
//  Sits between the CPU top and the memory/peripheral bus; produces the CPU's MIO_ready-style ready.
// PARAMETERS
//  AW       32   address width
//  DW       32   data width
//  TIMEOUT  255  cycles in BUSY without mem_ack before abort (ARB_TIMEOUT_EN only), 1..65535
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   asynchronous, active-low (0 = reset)
//  m0_req     in   1   M0 request; held high until m0_ready
//  m0_we      in   1   M0 write enable (1 = write)
//  m0_addr    in   AW  M0 address
//  m0_wdata   in   DW  M0 write data
//  m0_rdata   out  DW  M0 read data, valid while m0_ready=1
//  m0_ready   out  1   one-cycle completion pulse to M0
//  m1_req/m1_we/m1_addr/m1_wdata/m1_rdata/m1_ready   same as M0, for M1
//  mem_req    out  1   bus request, held until mem_ack
//  mem_we     out  1   bus write enable
//  mem_addr   out  AW  bus address
//  mem_wdata  out  DW  bus write data
//  mem_rdata  in   DW  bus read data, sampled when mem_ack=1
//  mem_ack    in   1   bus completion, one-cycle pulse
//  grant      out  2   one-hot current owner ({M1,M0}), 00 when idle
//  arb_err    out  1   one-cycle pulse on timeout abort (0 without ARB_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset: state=IDLE, all outputs 0, last-served pointer rr_last=1 (M0 wins first tie); mem_req drops immediately.
//  - FSM: IDLE(2'b00) -> BUSY(2'b01) -> DONE(2'b10) -> IDLE. 2'b11 illegal, goes to IDLE.
//  - IDLE: only one req -> grant it; both -> grant master != rr_last; none -> stay.
//    On grant edge: latch we/addr/wdata of winner into bus regs, set grant, rr_last=winner, go BUSY.
//  - BUSY: mem_req=1 with latched fields (stable through the transaction; master input changes ignored).
//    mem_ack=1 -> latch mem_rdata (reads; writes leave rdata unchanged) into owner's rdata reg,
//    mem_req=0, go DONE.
//  - DONE: owner's ready=1 for exactly this cycle; grant stays; all reqs ignored; next cycle IDLE, grant=00.
//  - Latency: req high in cycle 0 (IDLE) -> mem_req high cycle 1 -> ack in cycle k -> ready in cycle k+1.
//    Zero-wait memory (ack in cycle 1): ready in cycle 2, 3-cycle transaction.
//  - Back-to-back: req still high in IDLE after DONE = new transaction; with both masters requesting
//    continuously grants alternate M0,M1,M0,...
//  - Req withdrawn during BUSY: transaction still completes; ready still pulses.
//  - mem_ack in IDLE or DONE: ignored, no state or data change.
//  - Non-owner rdata holds its last value; non-owner ready stays 0.
//  - Async reset mid-BUSY aborts the transaction silently; no ready, no err.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: 16-bit counter clears on entry to BUSY, increments each BUSY cycle without ack;
//    at count==TIMEOUT -> mem_req=0, owner rdata=32'hDEAD_BEEF, arb_err pulses in DONE with ready.
//    ack in the same cycle as the limit wins (normal completion, no err).
//  Not defined: no counter, arb_err tied 0, BUSY waits for mem_ack indefinitely.
// STRUCTURE
//  Package mem_arb_pkg: state localparams ST_IDLE/ST_BUSY/ST_DONE, ERR_RDATA=32'hDEAD_BEEF,
//    M0/M1 index constants.
//  Sub-module arb_timeout_cnt (clear, enable, hit), instantiated only under ARB_TIMEOUT_EN.
//  Rest (round-robin pick, FSM, bus regs, rdata regs) in this module.
// TESTING
//  T1 m0_req read addr 0x0000_0010, mem acks cycle 1 with 0x1234_5678 -> m0_ready cycle 2, m0_rdata=0x1234_5678.
//  T2 m0_req & m1_req raised together after reset, held 4 txns -> grant order M0,M1,M0,M1.
//  T3 m1 write addr 0x8, wdata 0xA5A5_A5A5, ack after 5 wait cycles -> mem fields stable 6 cycles, m1_ready once.
//  T4 reset driven 0 in BUSY cycle 2 -> mem_req/grant 0 immediately; after release M0 wins next tie.
//  T5 (ARB_TIMEOUT_EN, TIMEOUT=4) no ack -> mem_req drops after 4 BUSY cycles, rdata=0xDEAD_BEEF, arb_err+ready 1 cycle.
//  T6 spurious mem_ack in IDLE, and m0_req dropped mid-BUSY -> no state change / ready still pulses.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the two-master memory bus arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE=00, BUSY=01, DONE=10; 11 is illegal)
//   ERR_RDATA   : read data returned to the owner on a timeout abort
//   M0 / M1     : master index constants, also bit positions within grant
//   rr_pick     : round-robin winner selection between the two requesters
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } arb_state_e;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // A lone requester always wins; on a tie the master that was not served
  // last wins. Result is only meaningful when at least one request is high.
  function automatic logic rr_pick(input logic req0, input logic req1,
                                   input logic last);
    if (req0 && !req1) begin
      return M0;
    end else if (!req0 && req1) begin
      return M1;
    end else begin
      return (last == M0) ? M1 : M0;
    end
  endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// arb_timeout_cnt: 16-bit BUSY-cycle watchdog for mem_bus_arbiter.
// Only compiled when ARB_TIMEOUT_EN is defined.
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   clear  in  hold count at zero (asserted whenever the arbiter is not BUSY)
//   enable in  count this cycle (BUSY without mem_ack)
//   hit    out high in the LIMIT-th consecutive enabled cycle
`ifdef ARB_TIMEOUT_EN
module arb_timeout_cnt #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  // Counter starts at 0 in the first BUSY cycle, so the LIMIT-th waiting
  // cycle is the one where count_q == LIMIT-1.
  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign hit = enable && (count_q == LAST);

endmodule
`endif

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory/IO bus between M0 (multicycle CPU) and
// M1 (DMA / display fetch). Round-robin, one transaction at a time:
// IDLE -> BUSY (mem_req held until mem_ack) -> DONE (owner ready pulse) -> IDLE.
// Ports:
//   clk, reset                 clock; asynchronous active-low reset
//   mX_req/we/addr/wdata       master X request and transaction fields
//   mX_rdata, mX_ready         master X read data and one-cycle completion
//   mem_req/we/addr/wdata      bus side, fields latched at grant
//   mem_rdata, mem_ack         bus read data and one-cycle completion
//   grant                      one-hot owner {M1,M0}, 00 when idle
//   arb_err                    one-cycle pulse with ready on timeout abort
// Optional feature: define ARB_TIMEOUT_EN to abort a BUSY transaction after
// TIMEOUT cycles without mem_ack; otherwise arb_err is 0 and BUSY waits forever.
module mem_bus_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ready,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [1:0]    grant,
  output logic          arb_err
);

  import mem_arb_pkg::*;

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT must be in 1..65535");
  end

  arb_state_e    state_q,     state_d;
  logic [1:0]    grant_q,     grant_d;
  logic          rr_last_q,   rr_last_d;
  logic          bus_we_q,    bus_we_d;
  logic [AW-1:0] bus_addr_q,  bus_addr_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;
  logic [DW-1:0] m0_rdata_q,  m0_rdata_d;
  logic [DW-1:0] m1_rdata_q,  m1_rdata_d;
  logic          winner;

`ifdef ARB_TIMEOUT_EN
  logic arb_err_q, arb_err_d;
  logic to_hit;

  arb_timeout_cnt #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (reset),
    .clear  (state_q != ST_BUSY),
    .enable ((state_q == ST_BUSY) && !mem_ack),
    .hit    (to_hit)
  );
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_last_d   = rr_last_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
`ifdef ARB_TIMEOUT_EN
    arb_err_d   = 1'b0;
`endif
    winner      = rr_pick(m0_req, m1_req, rr_last_q);

    case (state_q)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          state_d   = ST_BUSY;
          rr_last_d = winner;
          if (winner == M1) begin
            grant_d     = 2'b10;
            bus_we_d    = m1_we;
            bus_addr_d  = m1_addr;
            bus_wdata_d = m1_wdata;
          end else begin
            grant_d     = 2'b01;
            bus_we_d    = m0_we;
            bus_addr_d  = m0_addr;
            bus_wdata_d = m0_wdata;
          end
        end
      end

      ST_BUSY: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (mem_ack) begin
          state_d = ST_DONE;
          if (!bus_we_q) begin
            if (grant_q[M1]) begin
              m1_rdata_d = mem_rdata;
            end else begin
              m0_rdata_d = mem_rdata;
            end
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (to_hit) begin
          state_d   = ST_DONE;
          arb_err_d = 1'b1;
          if (grant_q[M1]) begin
            m1_rdata_d = DW'(ERR_RDATA);
          end else begin
            m0_rdata_d = DW'(ERR_RDATA);
          end
        end
`endif
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_last_q   <= M1;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
`ifdef ARB_TIMEOUT_EN
      arb_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_last_q   <= rr_last_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
`ifdef ARB_TIMEOUT_EN
      arb_err_q   <= arb_err_d;
`endif
    end
  end

  // Request and ready decode straight from state so an async reset drops
  // them in the same instant.
  assign mem_req   = (state_q == ST_BUSY);
  assign mem_we    = (state_q == ST_BUSY) && bus_we_q;
  assign mem_addr  = bus_addr_q;
  assign mem_wdata = bus_wdata_q;
  assign grant     = grant_q;
  assign m0_ready  = (state_q == ST_DONE) && grant_q[M0];
  assign m1_ready  = (state_q == ST_DONE) && grant_q[M1];
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

`ifdef ARB_TIMEOUT_EN
  assign arb_err = arb_err_q;
`else
  assign arb_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int unsigned AW         = 32;
  localparam int unsigned DW         = 32;
  localparam int unsigned TB_TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic [DW-1:0] m0_rdata;
  logic          m0_ready;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic [DW-1:0] m1_rdata;
  logic          m1_ready;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic [1:0]    grant;
  logic          arb_err;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_rdata  (m0_rdata),
    .m0_ready  (m0_ready),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_rdata  (m1_rdata),
    .m1_ready  (m1_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .grant     (grant),
    .arb_err   (arb_err)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    int unsigned wait_n;
    logic [31:0] ack_data;
    logic [1:0]  exp_grant;
    logic        exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_r0, exp_r1;
  } vec_t;

  vec_t vecs[6];

  // One transaction: called at an IDLE negedge, returns at the following IDLE negedge.
  task automatic run_vec(input vec_t v);
    chk("idle_grant", 64'(grant), 64'(2'b00));
    chk("idle_mem_req", 64'(mem_req), 64'(1'b0));
    m0_req = v.req0; m0_we = v.we0; m0_addr = v.addr0; m0_wdata = v.wdata0;
    m1_req = v.req1; m1_we = v.we1; m1_addr = v.addr1; m1_wdata = v.wdata1;
    @(negedge clk);
    chk("busy_grant", 64'(grant), 64'(v.exp_grant));
    chk("busy_mem_req", 64'(mem_req), 64'(1'b1));
    chk("busy_mem_we", 64'(mem_we), 64'(v.exp_we));
    chk("busy_mem_addr", 64'(mem_addr), 64'(v.exp_addr));
    chk("busy_mem_wdata", 64'(mem_wdata), 64'(v.exp_wdata));
    // Master-side changes during BUSY must not reach the bus.
    m0_addr = ~m0_addr; m1_addr = ~m1_addr; m0_wdata = ~m0_wdata; m1_wdata = ~m1_wdata;
    m0_we = ~m0_we; m1_we = ~m1_we;
    for (int i = 0; i < int'(v.wait_n); i++) begin
      @(negedge clk);
      chk("wait_mem_req", 64'(mem_req), 64'(1'b1));
      chk("wait_mem_addr", 64'(mem_addr), 64'(v.exp_addr));
      chk("wait_mem_wdata", 64'(mem_wdata), 64'(v.exp_wdata));
      chk("wait_mem_we", 64'(mem_we), 64'(v.exp_we));
      chk("wait_no_ready", 64'({m1_ready, m0_ready}), 64'(2'b00));
    end
    mem_ack = 1'b1; mem_rdata = v.ack_data;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0F0F_0F0F;
    chk("done_mem_req", 64'(mem_req), 64'(1'b0));
    chk("done_grant", 64'(grant), 64'(v.exp_grant));
    chk("done_ready", 64'({m1_ready, m0_ready}), 64'(v.exp_grant));
    chk("done_m0_rdata", 64'(m0_rdata), 64'(v.exp_r0));
    chk("done_m1_rdata", 64'(m1_rdata), 64'(v.exp_r1));
    chk("done_arb_err", 64'(arb_err), 64'(1'b0));
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    chk("after_ready", 64'({m1_ready, m0_ready}), 64'(2'b00));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0] t2_exp [4];

    //               req0  req1  we0   we1   addr0     addr1     wdata0        wdata1        wait ack_data      grant  we    addr      wdata         r0            r1
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h10,  32'h0,   32'h0,        32'h0,        0, 32'h1234_5678, 2'b01, 1'b0, 32'h10,  32'h0,        32'h1234_5678, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,   32'h8,   32'h0,        32'hA5A5_A5A5, 5, 32'hDEAD_DEAD, 2'b10, 1'b1, 32'h8,   32'hA5A5_A5A5, 32'h1234_5678, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h200, 32'h0101_0101, 32'h0202_0202, 1, 32'hCAFE_F00D, 2'b01, 1'b0, 32'h100, 32'h0101_0101, 32'hCAFE_F00D, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h400, 32'h0303_0303, 32'h0404_0404, 2, 32'h0BAD_F00D, 2'b10, 1'b0, 32'h400, 32'h0404_0404, 32'hCAFE_F00D, 32'h0BAD_F00D};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h20,  32'h0,   32'h1111_2222, 32'h0,        0, 32'hFFFF_FFFF, 2'b01, 1'b1, 32'h20,  32'h1111_2222, 32'hCAFE_F00D, 32'h0BAD_F00D};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h44,  32'h0,        32'h0,        3, 32'h5555_AAAA, 2'b10, 1'b0, 32'h44,  32'h0,        32'hCAFE_F00D, 32'h5555_AAAA};

    // Reset state
    @(negedge clk);
    chk("rst_grant", 64'(grant), 64'(2'b00));
    chk("rst_mem_req", 64'(mem_req), 64'(1'b0));
    chk("rst_ready", 64'({m1_ready, m0_ready}), 64'(2'b00));
    chk("rst_m0_rdata", 64'(m0_rdata), 64'(32'h0));
    chk("rst_m1_rdata", 64'(m1_rdata), 64'(32'h0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(32'h0));
    chk("rst_arb_err", 64'(arb_err), 64'(1'b0));
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
    end

    // T2: fresh reset, both masters request continuously -> M0,M1,M0,M1
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    t2_exp[0] = 2'b01; t2_exp[1] = 2'b10; t2_exp[2] = 2'b01; t2_exp[3] = 2'b10;
    m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b0;
    m0_addr = 32'hA0; m1_addr = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_grant", 64'(grant), 64'(t2_exp[i]));
      chk("t2_mem_addr", 64'(mem_addr), (t2_exp[i] == 2'b01) ? 64'h A0 : 64'h B0);
      mem_ack = 1'b1; mem_rdata = 32'(i);
      @(negedge clk);
      mem_ack = 1'b0;
      chk("t2_ready", 64'({m1_ready, m0_ready}), 64'(t2_exp[i]));
      chk("t2_rdata", (t2_exp[i] == 2'b01) ? 64'(m0_rdata) : 64'(m1_rdata), 64'(i));
      @(negedge clk);
      chk("t2_idle_grant", 64'(grant), 64'(2'b00));
    end
    m0_req = 1'b0; m1_req = 1'b0;

    // T4: M0 wins alone (rr_last -> M0), async reset in BUSY cycle 2
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h50;
    @(negedge clk);
    chk("t4_grant", 64'(grant), 64'(2'b01));
    @(negedge clk);
    chk("t4_busy2_mem_req", 64'(mem_req), 64'(1'b1));
    #1 reset = 1'b0;
    #1;
    chk("t4_rst_mem_req", 64'(mem_req), 64'(1'b0));
    chk("t4_rst_grant", 64'(grant), 64'(2'b00));
    chk("t4_rst_ready", 64'({m1_ready, m0_ready}), 64'(2'b00));
    chk("t4_rst_m0_rdata", 64'(m0_rdata), 64'(32'h0));
    chk("t4_rst_arb_err", 64'(arb_err), 64'(1'b0));
    @(negedge clk);
    reset = 1'b1;
    m1_req = 1'b1; m1_addr = 32'h54;
    @(negedge clk);
    chk("t4_tie_after_reset", 64'(grant), 64'(2'b01));
    mem_ack = 1'b1; mem_rdata = 32'h4444_0000;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("t4_ready", 64'({m1_ready, m0_ready}), 64'(2'b01));
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);

    // T6: spurious ack in IDLE, req withdrawn in BUSY, spurious ack in DONE
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
    @(negedge clk);
    chk("t6_idle_ack_grant", 64'(grant), 64'(2'b00));
    chk("t6_idle_ack_mem_req", 64'(mem_req), 64'(1'b0));
    chk("t6_idle_ack_ready", 64'({m1_ready, m0_ready}), 64'(2'b00));
    chk("t6_idle_ack_m0_rdata", 64'(m0_rdata), 64'(32'h4444_0000));
    mem_ack = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h60;
    @(negedge clk);
    chk("t6_busy_mem_req", 64'(mem_req), 64'(1'b1));
    m0_req = 1'b0;
    @(negedge clk);
    chk("t6_withdrawn_mem_req", 64'(mem_req), 64'(1'b1));
    mem_ack = 1'b1; mem_rdata = 32'h600D_D00D;
    @(negedge clk);
    chk("t6_withdrawn_ready", 64'(m0_ready), 64'(1'b1));
    chk("t6_withdrawn_rdata", 64'(m0_rdata), 64'(32'h600D_D00D));
    mem_ack = 1'b1; mem_rdata = 32'hBAAD_BAAD;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("t6_done_ack_m0_rdata", 64'(m0_rdata), 64'(32'h600D_D00D));
    chk("t6_done_ack_grant", 64'(grant), 64'(2'b00));
    chk("t6_done_ack_ready", 64'(m0_ready), 64'(1'b0));
    @(negedge clk);
    chk("t6_stay_idle", 64'(mem_req), 64'(1'b0));

`ifdef ARB_TIMEOUT_EN
    // T5: no ack -> abort after TB_TIMEOUT BUSY cycles
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h70;
    @(negedge clk);
    chk("t5_grant", 64'(grant), 64'(2'b10));
    for (int i = 1; i < int'(TB_TIMEOUT); i++) begin
      @(negedge clk);
      chk("t5_wait_mem_req", 64'(mem_req), 64'(1'b1));
    end
    @(negedge clk);
    chk("t5_mem_req_dropped", 64'(mem_req), 64'(1'b0));
    chk("t5_arb_err", 64'(arb_err), 64'(1'b1));
    chk("t5_ready", 64'(m1_ready), 64'(1'b1));
    chk("t5_rdata", 64'(m1_rdata), 64'(32'hDEAD_BEEF));
    m1_req = 1'b0;
    @(negedge clk);
    chk("t5_arb_err_pulse", 64'(arb_err), 64'(1'b0));
    chk("t5_idle_grant", 64'(grant), 64'(2'b00));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
